main_memory_module: RTL and testbench
=====================================

MAIN_MEMORY_MODULE -- requirements
Module: main_memory_module

Interface
- REQ-001: Parameter DEPTH, default 256; number of 32-bit words stored; power of two, 4 to 65536.
- REQ-002: Parameter ADDR_LSB, default 2; byte-address bit where the word index starts (word-aligned byte addressing).
- REQ-003: clk  input  1  single clock; all writes occur on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-low reset.
- REQ-005: address  input  32  byte address from the ALU result.
- REQ-006: readEnable  input  1  1 = drive stored word on dataOut.
- REQ-007: writeEnable  input  1  1 = store dataIn at the next rising clk edge.
- REQ-008: dataIn  input  32  write data (register-file read port 2).
- REQ-009: dataOut  output  32  read data to the write-back mux.

Function
- REQ-010: SHALL form the word index as address[ADDR_LSB+log2(DEPTH)-1 : ADDR_LSB]; bits below ADDR_LSB are ignored (no misalignment fault).
- REQ-011: Read SHALL be combinational, zero latency: dataOut = mem[index] while readEnable=1, else 32'h0000_0000.
- REQ-012: Write SHALL occur on the rising clk edge when writeEnable=1 and rst=1: mem[index] <= dataIn.
- REQ-013: Read and write in the same cycle to the same index SHALL return the old word until the edge, then the new word combinationally after it.
- REQ-014: readEnable and writeEnable both 0 SHALL leave contents unchanged and drive dataOut = 0.
- REQ-015: Without the bounds-check feature, address bits above the index field SHALL be ignored (wrap-around modulo DEPTH words).
- REQ-016: Writes with writeEnable=1 SHALL be full 32-bit word writes; no byte enables.
- REQ-017: dataOut SHALL contain no X when readEnable=1 after reset.

Reset
- REQ-018: rst=0 SHALL immediately, independent of clk, clear every word to 32'h0000_0000.
- REQ-019: While rst=0, writes SHALL be ignored and dataOut SHALL be 0.
- REQ-020: rst deasserted in the same cycle as writeEnable=1 SHALL take effect on the first rising edge with rst=1.
- REQ-021: Reset asserted mid-operation SHALL discard any pending write of that cycle.

Configuration
- REQ-022: Macro MAIN_MEM_BOUNDS_CHECK_EN SHALL enable range checking of the full 32-bit address.
- REQ-023: With MAIN_MEM_BOUNDS_CHECK_EN defined, addresses >= DEPTH*4 SHALL read 32'h0000_0000 and SHALL not write (silent drop, contents unchanged).
- REQ-024: Without MAIN_MEM_BOUNDS_CHECK_EN, REQ-015 wrap-around behaviour SHALL apply and no comparison logic SHALL be synthesized.

Verification
- REQ-025: rst=0 pulse, then readEnable=1, address=0x0 and 0x3FC -> dataOut=0x00000000 both.
- REQ-026: writeEnable=1, address=0x10, dataIn=0xDEADBEEF, one edge; then readEnable=1, address=0x13 -> dataOut=0xDEADBEEF.
- REQ-027: Same cycle readEnable=1, writeEnable=1, address=0x20, old=0x11111111, dataIn=0x22222222 -> dataOut=0x11111111 before edge, 0x22222222 after.
- REQ-028: readEnable=0 with mem[4]=0x12345678, address=0x10 -> dataOut=0x00000000.
- REQ-029: DEPTH=256, write 0xCAFEF00D at address=0x400 -> without macro mem[0]=0xCAFEF00D; with MAIN_MEM_BOUNDS_CHECK_EN mem[0] unchanged and read at 0x400 returns 0.
- REQ-030: Write 0xA5A5A5A5 to 0x8, assert rst=0 between clock edges -> dataOut at 0x8 reads 0 immediately, before any further clk edge.

Source files
------------

// File: rtl/main_memory_module.sv
// main_memory_module: word-addressed data memory for a single-cycle datapath.
// Combinational (zero-latency) read gated by readEnable, synchronous full-word
// write on the rising clock edge, and asynchronous active-low clear of every word.
// Optional feature: define MAIN_MEM_BOUNDS_CHECK_EN to range-check the full
// 32-bit byte address (out-of-range reads return zero, writes are dropped).
// Without it, address bits above the index field are ignored (wrap-around).
module main_memory_module #(
  parameter int DEPTH    = 256,
  parameter int ADDR_LSB = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        readEnable,
  input  logic        writeEnable,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] index_s;
  logic          in_range_s;
  logic          unused_addr_s;

  // Word index taken from the byte address; sub-word bits are ignored.
  assign index_s = address[ADDR_LSB +: AW];

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
  localparam int HI_LSB = ADDR_LSB + AW;
  // Any set bit above the index field means the byte address is >= DEPTH words.
  assign in_range_s = ((address >> HI_LSB) == 32'd0);
`else
  // Upper address bits are ignored, so every access is in range.
  assign in_range_s = 1'b1;
`endif

  // Sub-word and (without range checking) upper address bits are intentionally unused.
  assign unused_addr_s = ^address;

  // Storage: async clear of every word on reset, full-word write on the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (writeEnable && in_range_s) begin
      mem_r[index_s] <= dataIn;
    end
  end

  // Zero-latency read; forced to zero when disabled, in reset or out of range.
  always_comb begin
    dataOut = 32'h0000_0000;
    if (rst && readEnable && in_range_s) begin
      dataOut = mem_r[index_s];
    end else begin
      dataOut = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_main_memory_module.sv
// Directed, table-driven self-checking bench for main_memory_module
// (DEPTH=256, ADDR_LSB=2). Expected values track MAIN_MEM_BOUNDS_CHECK_EN.
module tb_main_memory_module;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic        readEnable;
  logic        writeEnable;
  logic [31:0] dataIn;
  logic [31:0] dataOut;

  int checks = 0;
  int errors = 0;

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  main_memory_module #(.DEPTH(256), .ADDR_LSB(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .readEnable  (readEnable),
    .writeEnable (writeEnable),
    .dataIn      (dataIn),
    .dataOut     (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    writeEnable = we;
    readEnable  = re;
    address     = a;
    dataIn      = d;
  endtask

  initial begin
    // Vector table: dataOut expected 1 ns after driving, i.e. before the write edge.
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h1111_1111, 32'h0000_0000};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h2222_2222, 32'h1111_1111};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 32'h2222_2222};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 32'h0000_0000};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, BC ? 32'h0000_0000 : 32'hCAFE_F00D};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0000, BC ? 32'h0000_0000 : 32'hCAFE_F00D};
    vecs[13] = '{1'b0, 1'b1, 32'h8000_0010, 32'h0000_0000, BC ? 32'h0000_0000 : 32'h1234_5678};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_03FC, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[15] = '{1'b0, 1'b1, 32'h0000_03FE, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_03F8, 32'h0000_0001, 32'h0000_0000};
    vecs[17] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[18] = '{1'b0, 1'b1, 32'h0000_03F8, 32'h0000_0000, 32'h0000_0001};
    vecs[19] = '{1'b0, 1'b0, 32'h0000_0020, 32'hDEAD_0000, 32'h0000_0000};
    vecs[20] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 32'h2222_2222};
    vecs[21] = '{1'b1, 1'b1, 32'h8000_0024, 32'h0BAD_C0DE, 32'h0000_0000};
    vecs[22] = '{1'b0, 1'b1, 32'h0000_0024, 32'h0000_0000, BC ? 32'h0000_0000 : 32'h0BAD_C0DE};

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset state: every word reads zero, including while reset is held.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0010, 32'h0);
    #1 check("read_in_reset", dataOut, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h0000_0000, 32'h0);
    #1 check("reset_addr_0", dataOut, 32'h0000_0000);
    drive(1'b0, 1'b1, 32'h0000_03FC, 32'h0);
    #1 check("reset_addr_3fc", dataOut, 32'h0000_0000);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].din);
      #1 check($sformatf("vec%0d", i), dataOut, vecs[i].exp);
    end

    // Reset between clock edges clears contents immediately.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0000_0008, 32'hA5A5_A5A5);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0008, 32'h0);
    #1 check("a5_written", dataOut, 32'hA5A5_A5A5);
    #1 rst = 1'b0;
    #1 check("async_clear_out", dataOut, 32'h0000_0000);
    rst = 1'b1;
    #1 check("async_clear_mem", dataOut, 32'h0000_0000);
    drive(1'b0, 1'b1, 32'h0000_0020, 32'h0);
    #1 check("async_clear_other", dataOut, 32'h0000_0000);

    // Write held across an edge while in reset is dropped; the first edge
    // after release performs it.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 32'h0000_0008, 32'h0000_0077);
    @(negedge clk);
    #1 check("write_in_reset_out", dataOut, 32'h0000_0000);
    rst = 1'b1;
    #1 check("write_in_reset_dropped", dataOut, 32'h0000_0000);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0008, 32'h0);
    #1 check("write_after_release", dataOut, 32'h0000_0077);
    drive(1'b0, 1'b1, 32'h0000_0020, 32'h0);
    #1 check("other_still_clear", dataOut, 32'h0000_0000);

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
